// File: rtl/sram_arbiter_if.sv
// Request/response bundle between the two SRAM requesters and the arbiter.
// Per-requester fields are packed with requester i at slice i.
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]              req_valid;
    logic [1:0]              req_wen;
    logic [2*ADDR_WIDTH-1:0] req_addr;
    logic [2*DATA_WIDTH-1:0] req_wdat;
    logic [1:0]              req_ready;
    logic [1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdat;

    modport master (
        output req_valid,
        output req_wen,
        output req_addr,
        output req_wdat,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdat
    );

    modport slave (
        input  req_valid,
        input  req_wen,
        input  req_addr,
        input  req_wdat,
        output req_ready,
        output rsp_valid,
        output rsp_rdat
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts for a single-port
// synchronous SRAM; read data returns to the owning requester one cycle later.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    sram_arbiter_if.slave         req_bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_wen,
    output logic                  sram_ren,
    output logic [DATA_WIDTH-1:0] sram_wdat,
    input  logic [DATA_WIDTH-1:0] sram_rdat
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             last_grant_r;
    logic             fresh_r;
    logic [CNT_W-1:0] burst_cnt_r;
    logic [1:0]       rsp_valid_r;

    logic             grant_s;
    logic             grant_idx_s;
    logic             grant_wen_s;
    logic [1:0]       grant_onehot_s;

    // Grant selection: fresh_r makes requester 0 win the first tie after reset.
    always_comb begin
        grant_s     = 1'b0;
        grant_idx_s = 1'b0;
        if (!n_rst) begin
            grant_s     = 1'b0;
            grant_idx_s = 1'b0;
        end else begin
            case (req_bus.req_valid)
                2'b01: begin
                    grant_s     = 1'b1;
                    grant_idx_s = 1'b0;
                end
                2'b10: begin
                    grant_s     = 1'b1;
                    grant_idx_s = 1'b1;
                end
                2'b11: begin
                    grant_s = 1'b1;
                    if (fresh_r) begin
                        grant_idx_s = ~last_grant_r;
                    end else if (burst_cnt_r < CNT_MAX) begin
                        grant_idx_s = last_grant_r;
                    end else begin
                        grant_idx_s = ~last_grant_r;
                    end
                end
                default: begin
                    grant_s     = 1'b0;
                    grant_idx_s = 1'b0;
                end
            endcase
        end
    end

    // Decode the granted requester into ready, write flag and SRAM drive.
    always_comb begin
        grant_onehot_s = 2'b00;
        grant_wen_s    = 1'b0;
        sram_addr      = {ADDR_WIDTH{1'b0}};
        sram_wdat      = {DATA_WIDTH{1'b0}};
        sram_wen       = 1'b0;
        sram_ren       = 1'b0;
        if (grant_s) begin
            grant_wen_s = req_bus.req_wen[grant_idx_s];
            sram_wen    = grant_wen_s;
            sram_ren    = ~grant_wen_s;
            if (grant_idx_s) begin
                grant_onehot_s = 2'b10;
                sram_addr      = req_bus.req_addr[ADDR_WIDTH +: ADDR_WIDTH];
                sram_wdat      = req_bus.req_wdat[DATA_WIDTH +: DATA_WIDTH];
            end else begin
                grant_onehot_s = 2'b01;
                sram_addr      = req_bus.req_addr[0 +: ADDR_WIDTH];
                sram_wdat      = req_bus.req_wdat[0 +: DATA_WIDTH];
            end
        end else begin
            grant_onehot_s = 2'b00;
            grant_wen_s    = 1'b0;
        end
    end

    assign req_bus.req_ready = grant_onehot_s;
    assign req_bus.rsp_valid = rsp_valid_r;
    assign req_bus.rsp_rdat  = sram_rdat;

    // Arbitration history: owner, first-grant flag and saturating burst length.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            last_grant_r <= 1'b1;
            fresh_r      <= 1'b1;
            burst_cnt_r  <= {CNT_W{1'b0}};
        end else if (grant_s) begin
            last_grant_r <= grant_idx_s;
            fresh_r      <= 1'b0;
            if (grant_idx_s != last_grant_r) begin
                burst_cnt_r <= CNT_ONE;
            end else if (burst_cnt_r < CNT_MAX) begin
                burst_cnt_r <= burst_cnt_r + CNT_ONE;
            end else begin
                burst_cnt_r <= CNT_MAX;
            end
        end else begin
            burst_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Read response tag: follows the SRAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rsp_valid_r <= 2'b00;
        end else if (grant_s && !grant_wen_s) begin
            rsp_valid_r <= grant_onehot_s;
        end else begin
            rsp_valid_r <= 2'b00;
        end
    end

endmodule
